// File: rtl/multiband_eq_tdm.sv
// Stereo N-band parallel-biquad equaliser sharing one multiplier across all bands and gains.
// Optional macro EQ_BYPASS_EN adds a bypass input that passes the latched sample through unmodified.
module multiband_eq_tdm #(
  parameter int NUM_BANDS = 3,
  parameter int DATA_W    = 16,
  parameter int COEF_W    = 16,
  parameter int COEF_FRAC = 14,
  parameter int GUARD_W   = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           l_r_clk,
  input  logic signed [DATA_W-1:0]       audio_in,
  input  logic                           coef_wr_en,
  input  logic [$clog2(NUM_BANDS)+2:0]   coef_addr,
  input  logic signed [COEF_W-1:0]       coef_wdata,
  input  logic                           coef_commit,
`ifdef EQ_BYPASS_EN
  input  logic                           bypass,
`endif
  output logic signed [DATA_W-1:0]       audio_out,
  output logic                           out_ch,
  output logic                           out_valid,
  output logic                           busy,
  output logic                           overrun
);

  localparam int ACC_W  = DATA_W + COEF_W + GUARD_W;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int BAND_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;
  localparam logic [BAND_W-1:0] LAST_BAND = BAND_W'(NUM_BANDS - 1);
  localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(1 << COEF_FRAC);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

  function automatic logic signed [DATA_W-1:0] sat_shift(input logic signed [ACC_W-1:0] v);
    logic signed [ACC_W-1:0] s;
    s = v >>> COEF_FRAC;
    if (s > SAT_MAX)      return {1'b0, {(DATA_W-1){1'b1}}};
    else if (s < SAT_MIN) return {1'b1, {(DATA_W-1){1'b0}}};
    else                  return s[DATA_W-1:0];
  endfunction

  // Coefficient banks, index 0..4 = b0,b1,b2,a1,a2 and 5 = gain
  logic signed [COEF_W-1:0] r_sh  [NUM_BANDS][6];
  logic signed [COEF_W-1:0] r_act [NUM_BANDS][6];
  logic                     r_pending;

  logic signed [DATA_W-1:0] r_x1 [2][NUM_BANDS];
  logic signed [DATA_W-1:0] r_x2 [2][NUM_BANDS];
  logic signed [DATA_W-1:0] r_y1 [2][NUM_BANDS];
  logic signed [DATA_W-1:0] r_y2 [2][NUM_BANDS];

  state_t                   r_state;
  logic [BAND_W-1:0]        r_band;
  logic [2:0]               r_tap;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [ACC_W-1:0]  r_sum;
  logic signed [DATA_W-1:0] r_x;
  logic                     r_ch;
  logic                     r_bypass;
  logic                     r_lrclk_q;
  logic signed [DATA_W-1:0] r_audio_out;
  logic                     r_out_ch;
  logic                     r_out_valid;
  logic                     r_overrun;

  logic                     w_edge;
  logic                     w_do_copy;
  logic                     w_bypass_in;
  logic [BAND_W-1:0]        w_wr_band;
  logic [2:0]               w_wr_idx;
  logic                     w_wr_ok;
  logic signed [COEF_W-1:0] w_mul_a;
  logic signed [DATA_W-1:0] w_mul_b;
  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_sum_next;
  logic signed [DATA_W-1:0] w_band_res;

`ifdef EQ_BYPASS_EN
  assign w_bypass_in = bypass;
`else
  assign w_bypass_in = 1'b0;
`endif

  assign w_edge    = l_r_clk != r_lrclk_q;
  assign w_do_copy = (r_state == S_IDLE) && w_edge && (r_pending || coef_commit);
  assign w_wr_band = BAND_W'(coef_addr >> 3);
  assign w_wr_idx  = coef_addr[2:0];
  assign w_wr_ok   = coef_wr_en && (w_wr_idx <= 3'd5) && (int'(coef_addr >> 3) < NUM_BANDS);

  assign w_band_res = sat_shift(r_acc);
  assign w_mul_a    = r_act[r_band][r_tap];

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_mul_b = '0;
    case (r_tap)
      3'd0:    w_mul_b = r_x;
      3'd1:    w_mul_b = r_x1[r_ch][r_band];
      3'd2:    w_mul_b = r_x2[r_ch][r_band];
      3'd3:    w_mul_b = r_y1[r_ch][r_band];
      3'd4:    w_mul_b = r_y2[r_ch][r_band];
      3'd5:    w_mul_b = w_band_res;
      default: w_mul_b = '0;
    endcase
  end

  assign w_prod     = PROD_W'(w_mul_a) * PROD_W'(w_mul_b);
  assign w_prod_ext = ACC_W'(w_prod);
  assign w_sum_next = r_sum + w_prod_ext;

  // NOTE: the coefficient banks are small register arrays with a defined passthrough reset, not RAM.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending <= 1'b0;
      for (int b = 0; b < NUM_BANDS; b++) begin
        for (int i = 0; i < 6; i++) begin
          r_sh[b][i]  <= ((b == 0) && (i == 0 || i == 5)) ? COEF_ONE : '0;
          r_act[b][i] <= ((b == 0) && (i == 0 || i == 5)) ? COEF_ONE : '0;
        end
      end
    end else begin
      if (w_do_copy) begin
        r_act     <= r_sh;
        r_pending <= 1'b0;
      end else if (coef_commit) begin
        r_pending <= 1'b1;
      end
      if (w_wr_ok) r_sh[w_wr_band][w_wr_idx] <= coef_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_band      <= '0;
      r_tap       <= '0;
      r_acc       <= '0;
      r_sum       <= '0;
      r_x         <= '0;
      r_ch        <= 1'b0;
      r_bypass    <= 1'b0;
      r_lrclk_q   <= l_r_clk;
      r_audio_out <= '0;
      r_out_ch    <= 1'b0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
      for (int c = 0; c < 2; c++) begin
        for (int b = 0; b < NUM_BANDS; b++) begin
          r_x1[c][b] <= '0;
          r_x2[c][b] <= '0;
          r_y1[c][b] <= '0;
          r_y2[c][b] <= '0;
        end
      end
    end else begin
      r_lrclk_q   <= l_r_clk;
      r_out_valid <= 1'b0;
      if (w_edge && (r_state != S_IDLE)) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_edge) begin
            r_x      <= audio_in;
            r_ch     <= l_r_clk;
            r_bypass <= w_bypass_in;
            r_band   <= '0;
            r_tap    <= '0;
            r_sum    <= '0;
            r_state  <= S_MAC;
          end
        end
        S_MAC: begin
          if (r_tap == 3'd5) begin
            r_sum                <= w_sum_next;
            r_x2[r_ch][r_band]   <= r_x1[r_ch][r_band];
            r_x1[r_ch][r_band]   <= r_x;
            r_y2[r_ch][r_band]   <= r_y1[r_ch][r_band];
            r_y1[r_ch][r_band]   <= w_band_res;
            r_tap                <= '0;
            if (r_band == LAST_BAND) begin
              r_state     <= S_OUT;
              r_out_valid <= 1'b1;
              r_out_ch    <= r_ch;
              r_audio_out <= r_bypass ? r_x : sat_shift(w_sum_next);
            end else begin
              r_band <= r_band + 1'b1;
            end
          end else begin
            r_acc <= (r_tap == 3'd0) ? w_prod_ext : r_acc + w_prod_ext;
            r_tap <= r_tap + 3'd1;
          end
        end
        S_OUT:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign audio_out = r_audio_out;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;
  assign busy      = r_state != S_IDLE;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_multiband_eq_tdm.sv
// Directed testbench for multiband_eq_tdm at default parameters (3 bands, Q2.14 coefficients).
module tb_multiband_eq_tdm;
  localparam int NB = 3;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int AW = $clog2(NB) + 3;

  logic                 clk = 1'b0;
  logic                 reset = 1'b0;
  logic                 l_r_clk = 1'b1;
  logic signed [DW-1:0] audio_in = '0;
  logic                 coef_wr_en = 1'b0;
  logic [AW-1:0]        coef_addr = '0;
  logic signed [CW-1:0] coef_wdata = '0;
  logic                 coef_commit = 1'b0;
  logic                 bypass = 1'b0;
  logic signed [DW-1:0] audio_out;
  logic                 out_ch;
  logic                 out_valid;
  logic                 busy;
  logic                 overrun;

  int n_tests = 0;
  int n_fail  = 0;

  multiband_eq_tdm #(.NUM_BANDS(NB), .DATA_W(DW), .COEF_W(CW), .COEF_FRAC(14), .GUARD_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .l_r_clk(l_r_clk),
    .audio_in(audio_in),
    .coef_wr_en(coef_wr_en),
    .coef_addr(coef_addr),
    .coef_wdata(coef_wdata),
    .coef_commit(coef_commit),
`ifdef EQ_BYPASS_EN
    .bypass(bypass),
`endif
    .audio_out(audio_out),
    .out_ch(out_ch),
    .out_valid(out_valid),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; coef_wr_en = 1'b0; coef_commit = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic do_edge(input logic [DW-1:0] s);
    @(negedge clk);
    audio_in = s;
    l_r_clk  = ~l_r_clk;
  endtask

  task automatic write_coef(input logic [AW-1:0] a, input logic [CW-1:0] v);
    @(negedge clk);
    coef_wr_en = 1'b1; coef_addr = a; coef_wdata = v;
    @(negedge clk);
    coef_wr_en = 1'b0;
  endtask

  task automatic commit();
    @(negedge clk);
    coef_commit = 1'b1;
    @(negedge clk);
    coef_commit = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output logic [DW-1:0] d, output logic ch);
    lat = -1; d = '0; ch = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n; d = audio_out; ch = out_ch;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if ({audio_out, out_ch, out_valid, busy, overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got out=%h ch=%b v=%b busy=%b ovr=%b, want all 0",
               audio_out, out_ch, out_valid, busy, overrun);
    end
  endtask

  task automatic test_passthrough();
    do_edge(16'h1234);
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      n_tests++;
      if (busy !== (n <= 19)) begin
        n_fail++;
        $display("FAIL pass_busy E+%0d: got %b want %b", n, busy, (n <= 19));
      end
      n_tests++;
      if (out_valid !== (n == 19)) begin
        n_fail++;
        $display("FAIL pass_valid E+%0d: got %b want %b", n, out_valid, (n == 19));
      end
      if (n == 19) begin
        n_tests++;
        if (audio_out !== 16'h1234 || out_ch !== 1'b0) begin
          n_fail++;
          $display("FAIL pass_data: got %h ch=%b want 1234 ch=0", audio_out, out_ch);
        end
      end
    end
  endtask

  task automatic test_gain();
    int lat; logic [DW-1:0] d; logic ch;
    write_coef(5'h05, 16'h2000);
    do_edge(16'h4000); wait_valid(lat, d, ch);
    n_tests++;
    if (d !== 16'h4000) begin n_fail++; $display("FAIL gain_no_commit: got %h want 4000", d); end
    commit();
    do_edge(16'h4000); wait_valid(lat, d, ch);
    n_tests++;
    if (d !== 16'h2000 || lat != 19) begin
      n_fail++; $display("FAIL gain_half: got %h lat %0d want 2000 lat 19", d, lat);
    end
    // shadow gain 1.0, then commit + edge + write of 0.25 in one cycle
    write_coef(5'h05, 16'h4000);
    @(negedge clk);
    coef_commit = 1'b1; coef_wr_en = 1'b1; coef_addr = 5'h05; coef_wdata = 16'h1000;
    audio_in = 16'h4000; l_r_clk = ~l_r_clk;
    @(negedge clk);
    coef_commit = 1'b0; coef_wr_en = 1'b0;
    wait_valid(lat, d, ch);
    n_tests++;
    if (d !== 16'h4000) begin n_fail++; $display("FAIL gain_commit_at_edge: got %h want 4000", d); end
    commit();
    do_edge(16'h4000); wait_valid(lat, d, ch);
    n_tests++;
    if (d !== 16'h1000) begin n_fail++; $display("FAIL gain_write_after_copy: got %h want 1000", d); end
    write_coef(5'h06, 16'h7777);
    write_coef(5'h07, 16'h7777);
    write_coef(5'h18, 16'h7777);
    write_coef(5'h1D, 16'h7777);
    commit();
    do_edge(16'h4000); wait_valid(lat, d, ch);
    n_tests++;
    if (d !== 16'h1000) begin n_fail++; $display("FAIL ignored_writes: got %h want 1000", d); end
  endtask

  task automatic test_saturation();
    int lat; logic [DW-1:0] d; logic ch;
    write_coef(5'h05, 16'h7FFF);
    commit();
    do_edge(16'h7000); wait_valid(lat, d, ch);
    n_tests++;
    if (d !== 16'h7FFF) begin n_fail++; $display("FAIL sat_pos: got %h want 7fff", d); end
    do_edge(16'h9000); wait_valid(lat, d, ch);
    n_tests++;
    if (d !== 16'h8000) begin n_fail++; $display("FAIL sat_neg: got %h want 8000", d); end
  endtask

  task automatic test_channels();
    int lat; logic [DW-1:0] d; logic ch;
    logic [DW-1:0] ins [4];
    logic [DW-1:0] exps[4];
    logic          chs [4];
    ins  = '{16'd100, 16'd300, 16'd200, 16'd400};
    exps = '{16'd0,   16'd0,   16'd100, 16'd300};
    chs  = '{1'b0, 1'b1, 1'b0, 1'b1};
    @(negedge clk);
    l_r_clk = 1'b1;
    do_reset();
    write_coef(5'h00, 16'h0000);
    write_coef(5'h01, 16'h4000);
    commit();
    for (int k = 0; k < 4; k++) begin
      do_edge(ins[k]); wait_valid(lat, d, ch);
      n_tests++;
      if (d !== exps[k] || ch !== chs[k]) begin
        n_fail++;
        $display("FAIL chan[%0d]: got %0d ch=%b want %0d ch=%b", k, d, ch, exps[k], chs[k]);
      end
    end
  endtask

  task automatic test_overrun();
    int lat; int cnt; int vlat; logic [DW-1:0] d; logic ch;
    do_reset();
    n_tests++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun); end
    do_edge(16'h0100);
    repeat (5) @(negedge clk);
    audio_in = 16'h0200; l_r_clk = ~l_r_clk;
    cnt = 0; vlat = -1; d = '0;
    for (int n = 6; n <= 45; n++) begin
      @(negedge clk);
      if (out_valid) begin cnt++; vlat = n; d = audio_out; end
    end
    n_tests++;
    if (cnt != 1 || vlat != 19) begin
      n_fail++; $display("FAIL ovr_valid_count: got %0d at E+%0d want 1 at E+19", cnt, vlat);
    end
    n_tests++;
    if (d !== 16'h0100) begin n_fail++; $display("FAIL ovr_data: got %h want 0100", d); end
    n_tests++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    write_coef(5'h05, 16'h2000);
    do_edge(16'h0400);
    repeat (5) @(negedge clk);
    coef_commit = 1'b1;
    @(negedge clk);
    coef_commit = 1'b0;
    wait_valid(lat, d, ch);
    n_tests++;
    if (d !== 16'h0400) begin n_fail++; $display("FAIL commit_mid_busy_old: got %h want 0400", d); end
    do_edge(16'h0400); wait_valid(lat, d, ch);
    n_tests++;
    if (d !== 16'h0200 || lat != 19) begin
      n_fail++; $display("FAIL commit_mid_busy_new: got %h lat %0d want 0200 lat 19", d, lat);
    end
    n_tests++;
    if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
  endtask

  task automatic test_reset_abort();
    int lat; int cnt; logic [DW-1:0] d; logic ch;
    do_edge(16'h0555);
    repeat (8) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    n_tests++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL abort_busy: got busy=%b ovr=%b want 0 0", busy, overrun);
    end
    cnt = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    n_tests++;
    if (cnt != 0 || audio_out !== 16'h0000) begin
      n_fail++; $display("FAIL abort_no_valid: got %0d valids out=%h want 0 valids out=0000", cnt, audio_out);
    end
    do_edge(16'h0777); wait_valid(lat, d, ch);
    n_tests++;
    if (d !== 16'h0777 || lat != 19) begin
      n_fail++; $display("FAIL abort_passthrough: got %h lat %0d want 0777 lat 19", d, lat);
    end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_passthrough();
    test_gain();
    test_saturation();
    test_channels();
    test_overrun();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multiband_eq_tdm.md
Name: multiband_eq_tdm

Overview:
- Parametrised stereo N-band equaliser: next generation of the fixed three-band parallel-biquad equaliser.
- A single shared multiplier is time-multiplexed across NUM_BANDS biquads and per-band gains.
- Separate left/right filter state per band; coefficients and gains are runtime-writable through a shadow/commit interface.
- Sits between the I2S receiver and transmitter, processing one sample per l_r_clk edge.

Parameters:
NUM_BANDS, 3, number of parallel biquad bands (1..8)
DATA_W, 16, signed audio sample width
COEF_W, 16, signed coefficient/gain width
COEF_FRAC, 14, fractional bits of coefficients and gains (Q2.14 at defaults)
GUARD_W, 4, extra accumulator headroom bits; ACC_W = DATA_W+COEF_W+GUARD_W

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset
l_r_clk  in  1  I2S word select, synchronous to clk; each edge delivers a new sample, level after edge = channel (0 left, 1 right)
audio_in  in  DATA_W  signed input sample, valid in the edge cycle
coef_wr_en  in  1  shadow-bank write strobe
coef_addr  in  $clog2(NUM_BANDS)+3  {band, idx}: idx 0..4 = b0,b1,b2,a1,a2; 5 = gain; 6,7 ignored
coef_wdata  in  COEF_W  value written
coef_commit  in  1  one-cycle pulse: request shadow->active copy
audio_out  out  DATA_W  signed equalised sample
out_ch  out  1  channel of audio_out
out_valid  out  1  one-cycle pulse when audio_out updates
busy  out  1  high while FSM is not IDLE
overrun  out  1  sticky: edge arrived while busy

Behaviour:
- Reset (reset==0 at clk edge): all outputs 0; all x1/x2/y1/y2 state for both channels 0; FSM IDLE; pending commit cleared.
- Both banks reset to passthrough: band 0 b0 = 1.0, gain = 1.0; every other coefficient and gain is 0.
- Edge detect: edge = l_r_clk != l_r_clk_q. Call the detect cycle E.
- In IDLE at E: latch audio_in and channel; if a commit is pending, copy shadow->active and clear pending; go to MAC.
- Difference equation: y = b0*x + b1*x1 + b2*x2 + a1*y1 + a2*y2. Feedback signs are pre-folded into a1/a2 (no subtraction in hardware).
- Per band, 6 cycles: 5 coefficient MACs into the ACC_W band accumulator.
- Band result = saturate_DATA_W(acc >>> COEF_FRAC), arithmetic shift (floor).
- 6th cycle per band: the band result times gain[b] is added to the ACC_W sum accumulator; that band's x2<=x1, x1<=x, y2<=y1, y1<=band result for the active channel only.
- Bands are processed in order 0..NUM_BANDS-1. After the last band the FSM enters OUT.
- OUT: audio_out = saturate_DATA_W(sum >>> COEF_FRAC); out_ch = latched channel; out_valid = 1 for exactly that cycle.
- Latency: out_valid asserts in cycle E+6*NUM_BANDS+1 (E+19 at defaults); FSM returns to IDLE the following cycle.
- States: IDLE -> MAC (6*NUM_BANDS cycles, counters band/tap) -> OUT -> IDLE.
- busy = 1 from E+1 through the OUT cycle.
- Edge while busy (including in the OUT cycle): sample dropped; overrun <= 1 and stays set until reset; the computation in flight is unaffected.
- Saturation clamps to 0x7FFF / 0x8000 (at DATA_W=16). Band results are saturated before filter state update, so state never wraps.
- Shadow writes are accepted in any cycle and never alter the active bank directly.
- Commit is held pending until the next IDLE edge, so in-flight samples always use one consistent bank.
- coef_commit and an edge in the same IDLE cycle: the copy happens first, and that sample uses the new bank.
- A coef_wr_en coincident with a commit copy writes the shadow after the copy (not in this copy).
- Writes to idx 6/7 or to band >= NUM_BANDS are ignored.
- reset asserted mid-computation: abort immediately to IDLE; outputs are not driven valid.

Optional Feature:
- Macro EQ_BYPASS_EN adds input port bypass (1 bit).
- With the macro defined and bypass==1 at E: the OUT cycle presents the latched input sample unmodified with normal latency and out_valid. The MAC cycles still run, so filter state keeps tracking the input and un-bypassing is click-free.
- Without the macro: no bypass port; always equalised.

Test Plan:
- Reset then left edge with audio_in=0x1234 -> out_valid at E+19, audio_out=0x1234, out_ch=0; busy high E+1..E+19.
- Write band0 gain=0x2000 (0.5), commit, edge with 0x4000 -> audio_out=0x2000; without commit the output stays 0x4000.
- Band0 gain=0x7FFF, commit; inputs 0x7000 then 0x9000 -> audio_out 0x7FFF then 0x8000.
- Band0 b0=0, b1=0x4000, commit; L inputs 100,200 interleaved with R inputs 300,400 -> L outputs 0,100; R outputs 0,300 (independent channel state).
- Second l_r_clk edge 5 cycles after the first -> overrun=1, exactly one out_valid, result equals the first sample's. Commit issued mid-busy -> current sample uses old bank, next sample uses new bank.
- Assert reset at E+8 -> busy=0 and no out_valid; the next edge yields passthrough output.
